rx_packet_parser: RTL

//  Drains the host-to-FPGA rx FIFO that the USB gateway fills. Frames the raw 32-bit word stream into packets
//  (header, payload, XOR trailer) and presents payload on a valid/ready stream to the master logic.

---
 rtl/rx_pkt_pkg.sv | 45 ++++
 rtl/rx_skid_buf.sv | 48 ++++
 rtl/rx_packet_parser.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rx_pkt_pkg.sv
// Shared definitions for the rx packet parser: header field layout, FSM states
// and the output buffer entry format.
package rx_pkt_pkg;

    localparam logic [7:0]  MAGIC_DEFAULT = 8'hA5;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned CHAN_W        = 8;
    localparam int unsigned LEN_W         = 11;
    localparam int unsigned RSVD_W        = 5;

    localparam int unsigned HDR_MAGIC_LSB = 24;
    localparam int unsigned HDR_CHAN_LSB  = 16;
    localparam int unsigned HDR_RSVD_LSB  = 11;
    localparam int unsigned HDR_LEN_LSB   = 0;

    typedef enum logic [2:0] {
        HUNT    = 3'b001,
        PAYLOAD = 3'b010,
        TRAILER = 3'b100
    } rx_state_e;

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic              last;
        logic [DATA_W-1:0] data;
    } buf_entry_t;

    function automatic logic [7:0] hdr_magic(input logic [DATA_W-1:0] w);
        return w[HDR_MAGIC_LSB +: 8];
    endfunction

    function automatic logic [CHAN_W-1:0] hdr_chan(input logic [DATA_W-1:0] w);
        return w[HDR_CHAN_LSB +: CHAN_W];
    endfunction

    function automatic logic [RSVD_W-1:0] hdr_rsvd(input logic [DATA_W-1:0] w);
        return w[HDR_RSVD_LSB +: RSVD_W];
    endfunction

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] w);
        return w[HDR_LEN_LSB +: LEN_W];
    endfunction

endpackage

// File: rtl/rx_skid_buf.sv
// Two-entry output buffer of {chan, last, data}; the head entry drives the
// valid/ready stream and is held until accepted.
module rx_skid_buf
    import rx_pkt_pkg::*;
(
    input  logic       usb_clk,
    input  logic       rst,
    input  logic       push,
    input  buf_entry_t push_entry,
    output buf_entry_t head,
    output logic       valid,
    input  logic       ready,
    output logic [1:0] count
);

    buf_entry_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       pop;

    assign valid = (count != 2'd0);
    assign pop   = valid && ready;
    assign head  = mem[rd_ptr];

    always_ff @(posedge usb_clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rx_packet_parser.sv
// Frames the rx FIFO word stream into header/payload/trailer packets, streams
// payload with its channel tag, and reports framing and checksum errors.
module rx_packet_parser
    import rx_pkt_pkg::*;
#(
    parameter logic [7:0]  MAGIC   = MAGIC_DEFAULT,
    parameter int unsigned MAX_LEN = 1024,
    parameter int unsigned ERR_W   = 16
) (
    input  logic             usb_clk,
    input  logic             rst,
    input  logic             rx_fifo_empty,
    input  logic [31:0]      rx_fifo_data,
    output logic             rx_fifo_read,
    output logic [31:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [7:0]       m_chan,
    output logic             pkt_done,
    output logic             pkt_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    rx_state_e         state, state_n;
    logic              rd_d;
    logic [CHAN_W-1:0] chan_q, chan_n;
    logic [LEN_W-1:0]  rem_q, rem_n;
    logic [DATA_W-1:0] csum_q, csum_n;
    logic              push;
    buf_entry_t        push_entry;
    buf_entry_t        head;
    logic              err_p, done_p;
    logic [1:0]        occ;
    logic [1:0]        occ_eff;
    logic              pop;

    rx_skid_buf u_buf (
        .usb_clk    (usb_clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .head       (head),
        .valid      (m_valid),
        .ready      (m_ready),
        .count      (occ)
    );

    assign m_data = head.data;
    assign m_last = head.last;
    assign m_chan = head.chan;

    // Occupancy is counted after this cycle's pop so a steady 1 word/cycle is
    // sustained; a read at N is pushed at N+1, so the buffer holds at most 2.
    assign pop          = m_valid && m_ready;
    assign occ_eff      = occ - {1'b0, pop};
    assign rx_fifo_read = !rst && !rx_fifo_empty && ((occ_eff + {1'b0, rd_d}) < 2'd2);

    always_ff @(posedge usb_clk) begin
        if (rst) begin
            state     <= HUNT;
            rd_d      <= 1'b0;
            chan_q    <= '0;
            rem_q     <= '0;
            csum_q    <= '0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
            err_count <= '0;
        end else begin
            state    <= state_n;
            rd_d     <= rx_fifo_read;
            chan_q   <= chan_n;
            rem_q    <= rem_n;
            csum_q   <= csum_n;
            pkt_done <= done_p;
            pkt_err  <= err_p;
            if (err_p && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

    always_comb begin
        state_n    = state;
        chan_n     = chan_q;
        rem_n      = rem_q;
        csum_n     = csum_q;
        push       = 1'b0;
        push_entry = '0;
        err_p      = 1'b0;
        done_p     = 1'b0;
        if (rd_d) begin
            case (state)
                HUNT: begin
                    if (hdr_magic(rx_fifo_data) == MAGIC) begin
                        chan_n = hdr_chan(rx_fifo_data);
                        if ((hdr_len(rx_fifo_data) == '0) ||
                            (hdr_len(rx_fifo_data) > MAX_LEN_L) ||
                            (hdr_rsvd(rx_fifo_data) != '0)) begin
                            err_p = 1'b1;
                        end else begin
                            state_n = PAYLOAD;
                            csum_n  = '0;
                            rem_n   = hdr_len(rx_fifo_data);
                        end
                    end
                end
                PAYLOAD: begin
                    push            = 1'b1;
                    push_entry.chan = chan_q;
                    push_entry.last = (rem_q == LEN_W'(1));
                    push_entry.data = rx_fifo_data;
                    csum_n          = csum_q ^ rx_fifo_data;
                    rem_n           = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_n = TRAILER;
                    end
                end
                TRAILER: begin
                    done_p  = 1'b1;
                    err_p   = (rx_fifo_data != csum_q);
                    state_n = HUNT;
                end
                default: state_n = HUNT;
            endcase
        end
    end

endmodule
